// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the hazard controller
package hazard_controller_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RST_FLUSH = 2'd0,
    ST_RUN       = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALTED    = 2'd3
  } state_e;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ex_slot_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
  } wr_slot_t;

  // x0 is hardwired, so a zero destination never produces a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_controller_fwd_unit.sv
// rtl/hazard_controller_fwd_unit.sv - MEM-over-WB forwarding priority compare for one operand
module hazard_fwd_unit
  import hazard_controller_pkg::*;
(
  input  logic              ex_v,
  input  logic [REG_AW-1:0] rs,
  input  wr_slot_t          mem,
  input  wr_slot_t          wb,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_v) begin
      if (mem.v && mem.we && reg_match(mem.rd, rs)) begin
        sel = FWD_MEM;
      end else if (wb.v && wb.we && reg_match(wb.rd, rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - shadow EX/MEM/WB scoreboard driving stall, flush and forwarding
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            PCSrcE,
  input  logic            halt_req,
  output logic            stall_if,
  output logic            stall_id,
  output logic            flush_id,
  output logic            flush_ex,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            running,
  output logic            halted
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  ex_slot_t          ex;
  wr_slot_t          mem, wb;
  logic [REG_AW-1:0] rs1_n, rs2_n, rd_n;
  logic [1:0]        fwd_a_raw, fwd_b_raw;
  logic              load_use, drained;

  assign rs1_n = REG_AW'(id_rs1);
  assign rs2_n = REG_AW'(id_rs2);
  assign rd_n  = REG_AW'(id_rd);

  assign load_use = ex.v && ex.ld && ex.we &&
                    ((id_uses_rs1 && reg_match(ex.rd, rs1_n)) ||
                     (id_uses_rs2 && reg_match(ex.rd, rs2_n)));
  assign drained  = !ex.v && !mem.v && !wb.v;

  hazard_fwd_unit u_fwd_a (
    .ex_v (ex.v),
    .rs   (ex.rs1),
    .mem  (mem),
    .wb   (wb),
    .sel  (fwd_a_raw)
  );

  hazard_fwd_unit u_fwd_b (
    .ex_v (ex.v),
    .rs   (ex.rs2),
    .mem  (mem),
    .wb   (wb),
    .sel  (fwd_b_raw)
  );

  always_comb begin
    state_nxt = state;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    fwd_a_sel = fwd_a_raw;
    fwd_b_sel = fwd_b_raw;
    running   = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_RST_FLUSH: begin
        stall_if  = 1'b1;
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (cnt == '0) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        running = 1'b1;
        // A resolved redirect squashes the dependent instruction, so it beats load-use.
        if (PCSrcE) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        if (halt_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (PCSrcE) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        if (drained) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        halted   = 1'b1;
        if (!halt_req) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RST_FLUSH;
      cnt   <= CNT_INIT;
      ex    <= '0;
      mem   <= '0;
      wb    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RST_FLUSH) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        ex  <= '0;
        mem <= '0;
        wb  <= '0;
      end else begin
        ex.v   <= !flush_ex;
        ex.rd  <= rd_n;
        ex.we  <= id_regwrite;
        ex.ld  <= id_is_load;
        ex.rs1 <= rs1_n;
        ex.rs2 <= rs2_n;
        mem.v  <= ex.v;
        mem.rd <= ex.rd;
        mem.we <= ex.we;
        wb     <= mem;
      end
    end
  end

endmodule
